// File: rtl/unit_slot_p.sv
// Lane-unit slot: spawn, march toward the opposing front, attack on a cooldown, die and free the slot.
// Optional health regeneration is built when UNIT_REGEN_EN is defined.
`timescale 1ns/1ps
module unit_slot_p #(
  parameter int unsigned POS_W      = 9,
  parameter int unsigned HP_W       = 8,
  parameter int unsigned DIR        = 0,
  parameter int unsigned HP1        = 255,
  parameter int unsigned HP2        = 191,
  parameter int unsigned HP3        = 127,
  parameter int unsigned PWR1       = 32,
  parameter int unsigned PWR2       = 64,
  parameter int unsigned PWR3       = 128,
  parameter int unsigned ATK_PERIOD = 2,
  parameter int unsigned DEATH_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_tick,
  input  logic             dmg_valid,
  input  logic [HP_W-1:0]  dmg_in,
  input  logic             spawn_req,
  input  logic [1:0]       spawn_type,
  input  logic [POS_W-1:0] enemy_front,
  output logic [POS_W-1:0] position,
  output logic [HP_W-1:0]  damage_out,
  output logic [1:0]       unit_type,
  output logic             dead,
  output logic             attacking,
  output logic             at_base
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEPLOY = 3'd1;
  localparam logic [2:0] S_ALIVE  = 3'd2;
  localparam logic [2:0] S_DYING  = 3'd3;

  localparam int unsigned CD_W = (ATK_PERIOD > 1) ? $clog2(ATK_PERIOD) : 1;
  localparam int unsigned HD_W = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
  localparam logic [POS_W-1:0] SPAWN = (DIR == 0) ? {POS_W{1'b1}} : {POS_W{1'b0}};
  localparam logic [POS_W-1:0] FAR   = (DIR == 0) ? {POS_W{1'b0}} : {POS_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [HP_W-1:0]  pwr_q, pwr_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic [HD_W-1:0]  hold_q, hold_d;
  logic [HP_W-1:0]  dmg_q, dmg_d;
  logic             atk_q, atk_d;
  logic             engaged, kill;
`ifdef UNIT_REGEN_EN
  logic [2:0]       regen_q, regen_d;
`endif

  function automatic logic [HP_W-1:0] hp_of(input logic [1:0] t);
    case (t)
      2'd1:    return HP_W'(HP1);
      2'd2:    return HP_W'(HP2);
      2'd3:    return HP_W'(HP3);
      default: return '0;
    endcase
  endfunction

  function automatic logic [HP_W-1:0] pwr_of(input logic [1:0] t);
    case (t)
      2'd1:    return HP_W'(PWR1);
      2'd2:    return HP_W'(PWR2);
      2'd3:    return HP_W'(PWR3);
      default: return '0;
    endcase
  endfunction

  assign engaged = (DIR == 0) ? (enemy_front >= pos_q) : (enemy_front <= pos_q);
  assign kill    = dmg_valid && (dmg_in >= hp_q);

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pos_d   = pos_q;
    hp_d    = hp_q;
    pwr_d   = pwr_q;
    cd_d    = cd_q;
    hold_d  = hold_q;
    dmg_d   = dmg_q;
    atk_d   = 1'b0;
`ifdef UNIT_REGEN_EN
    regen_d = regen_q;
`endif
    case (state_q)
      S_IDLE: begin
        dmg_d = '0;
        if (spawn_req && spawn_type != 2'd0) begin
          type_d  = spawn_type;
          state_d = S_DEPLOY;
        end
      end
      S_DEPLOY: begin
        hp_d    = hp_of(type_q);
        pwr_d   = pwr_of(type_q);
        cd_d    = '0;
        pos_d   = SPAWN;
        dmg_d   = '0;
        state_d = S_ALIVE;
`ifdef UNIT_REGEN_EN
        regen_d = '0;
`endif
      end
      S_ALIVE: begin
        // A killing hit wins over any move/attack decided in the same cycle.
        if (kill) begin
          hp_d    = '0;
          dmg_d   = '0;
          hold_d  = '0;
          state_d = S_DYING;
        end else begin
          if (dmg_valid) hp_d = hp_q - dmg_in;
          if (move_tick) begin
            if (engaged) begin
              if (cd_q == '0) begin
                dmg_d = pwr_q;
                atk_d = 1'b1;
                cd_d  = CD_W'(ATK_PERIOD - 1);
              end else begin
                dmg_d = '0;
                cd_d  = cd_q - 1'b1;
              end
            end else begin
              dmg_d = '0;
              if (pos_q != FAR) pos_d = (DIR == 0) ? pos_q - 1'b1 : pos_q + 1'b1;
            end
`ifdef UNIT_REGEN_EN
            regen_d = regen_q + 1'b1;
            if (regen_q == 3'd7 && !dmg_valid && hp_q < hp_of(type_q)) hp_d = hp_q + 1'b1;
`endif
          end
        end
      end
      S_DYING: begin
        dmg_d = '0;
        if (move_tick) begin
          if (hold_q == HD_W'(DEATH_HOLD - 1)) begin
            state_d = S_IDLE;
            pos_d   = SPAWN;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        dmg_d   = '0;
        pos_d   = SPAWN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      pos_q   <= SPAWN;
      hp_q    <= '0;
      pwr_q   <= '0;
      cd_q    <= '0;
      hold_q  <= '0;
      dmg_q   <= '0;
      atk_q   <= 1'b0;
`ifdef UNIT_REGEN_EN
      regen_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pos_q   <= pos_d;
      hp_q    <= hp_d;
      pwr_q   <= pwr_d;
      cd_q    <= cd_d;
      hold_q  <= hold_d;
      dmg_q   <= dmg_d;
      atk_q   <= atk_d;
`ifdef UNIT_REGEN_EN
      regen_q <= regen_d;
`endif
    end
  end

  assign position   = pos_q;
  assign damage_out = dmg_q;
  assign attacking  = atk_q;
  assign unit_type  = (state_q == S_ALIVE) ? type_q : 2'd0;
  assign dead       = (state_q == S_IDLE);
  assign at_base    = (state_q == S_ALIVE) && (pos_q == FAR);

endmodule

// File: tb/tb_unit_slot_p.sv
// Bench for unit_slot_p: one DIR=0 and one DIR=1 slot checked every cycle against a behavioural model,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_unit_slot_p;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick[2];
  logic       dv[2];
  logic [7:0] dmgin[2];
  logic       spawn[2];
  logic [1:0] stype[2];
  logic [8:0] front[2];
  logic [8:0] pos_o[2];
  logic [7:0] dmg_o[2];
  logic [1:0] type_o[2];
  logic       dead_o[2];
  logic       att_o[2];
  logic       base_o[2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unit_slot_p #(.DIR(0)) u0 (
    .clk(clk), .reset(reset), .move_tick(tick[0]), .dmg_valid(dv[0]), .dmg_in(dmgin[0]),
    .spawn_req(spawn[0]), .spawn_type(stype[0]), .enemy_front(front[0]),
    .position(pos_o[0]), .damage_out(dmg_o[0]), .unit_type(type_o[0]), .dead(dead_o[0]),
    .attacking(att_o[0]), .at_base(base_o[0]));

  unit_slot_p #(.DIR(1)) u1 (
    .clk(clk), .reset(reset), .move_tick(tick[1]), .dmg_valid(dv[1]), .dmg_in(dmgin[1]),
    .spawn_req(spawn[1]), .spawn_type(stype[1]), .enemy_front(front[1]),
    .position(pos_o[1]), .damage_out(dmg_o[1]), .unit_type(type_o[1]), .dead(dead_o[1]),
    .attacking(att_o[1]), .at_base(base_o[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 free, 1 deploying, 2 fighting, 3 dying.
  int HPT[4] = '{0, 255, 191, 127};
  int PWT[4] = '{0, 32, 64, 128};
  int m_ph[2], m_pos[2], m_dmg[2], m_att[2], m_hp[2], m_pw[2], m_cd[2], m_hold[2], m_typ[2], m_rg[2];

  function automatic int spawn_pos(input int k); return (k == 0) ? 511 : 0; endfunction
  function automatic int far_pos(input int k);   return (k == 0) ? 0 : 511; endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_ph[k] = 0; m_pos[k] = spawn_pos(k); m_dmg[k] = 0; m_att[k] = 0;
        m_hp[k] = 0; m_cd[k] = 0; m_hold[k] = 0; m_typ[k] = 0; m_pw[k] = 0; m_rg[k] = 0;
      end else begin
        m_att[k] = 0;
        if (m_ph[k] == 0) begin
          if (spawn[k] && stype[k] != 0) begin m_typ[k] = int'(stype[k]); m_ph[k] = 1; end
        end else if (m_ph[k] == 1) begin
          m_hp[k] = HPT[m_typ[k]]; m_pw[k] = PWT[m_typ[k]]; m_cd[k] = 0; m_rg[k] = 0;
          m_pos[k] = spawn_pos(k); m_ph[k] = 2;
        end else if (m_ph[k] == 2) begin
          if (dv[k] && int'(dmgin[k]) >= m_hp[k]) begin
            m_hp[k] = 0; m_dmg[k] = 0; m_hold[k] = 0; m_ph[k] = 3;
          end else begin
            if (dv[k]) m_hp[k] -= int'(dmgin[k]);
            if (tick[k]) begin
              if ((k == 0) ? (int'(front[k]) >= m_pos[k]) : (int'(front[k]) <= m_pos[k])) begin
                if (m_cd[k] == 0) begin m_dmg[k] = m_pw[k]; m_att[k] = 1; m_cd[k] = 1; end
                else begin m_dmg[k] = 0; m_cd[k]--; end
              end else begin
                m_dmg[k] = 0;
                if (m_pos[k] != far_pos(k)) m_pos[k] += (k == 0) ? -1 : 1;
              end
`ifdef UNIT_REGEN_EN
              m_rg[k] = (m_rg[k] + 1) % 8;
              if (m_rg[k] == 0 && !dv[k] && m_hp[k] < HPT[m_typ[k]]) m_hp[k]++;
`endif
            end
          end
        end else begin
          m_dmg[k] = 0;
          if (tick[k]) begin
            m_hold[k]++;
            if (m_hold[k] == 4) begin m_ph[k] = 0; m_pos[k] = spawn_pos(k); end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d position", k), int'(pos_o[k]), m_pos[k]);
        chk($sformatf("u%0d damage_out", k), int'(dmg_o[k]), m_dmg[k]);
        chk($sformatf("u%0d unit_type", k), int'(type_o[k]), (m_ph[k] == 2) ? m_typ[k] : 0);
        chk($sformatf("u%0d dead", k), int'(dead_o[k]), (m_ph[k] == 0) ? 1 : 0);
        chk($sformatf("u%0d attacking", k), int'(att_o[k]), m_att[k]);
        chk($sformatf("u%0d at_base", k), int'(base_o[k]),
            (m_ph[k] == 2 && m_pos[k] == far_pos(k)) ? 1 : 0);
      end
    end
  end

  task automatic step(input int k, input logic t, input logic d, input int di);
    tick[k] = t; dv[k] = d; dmgin[k] = 8'(di);
    @(negedge clk);
    tick[k] = 1'b0; dv[k] = 1'b0;
  endtask

  task automatic spawn_unit(input int k, input int ty);
    spawn[k] = 1'b1; stype[k] = 2'(ty);
    @(negedge clk);
    spawn[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  int att_cnt;
  int seq[4];

  initial begin
    for (int k = 0; k < 2; k++) begin
      tick[k] = 0; dv[k] = 0; dmgin[k] = 0; spawn[k] = 0; stype[k] = 0; front[k] = 0;
    end
    @(negedge clk);
    chk("reset position u0", int'(pos_o[0]), 511);
    chk("reset position u1", int'(pos_o[1]), 0);
    chk("reset dead u0", int'(dead_o[0]), 1);
    #2 reset = 1'b0;

    // March toward far end with no opposition.
    front[0] = 9'd0;
    spawn_unit(0, 1);
    chk("t1 spawn position", int'(pos_o[0]), 511);
    chk("t1 unit_type", int'(type_o[0]), 1);
    for (int i = 0; i < 10; i++) step(0, 1'b1, 1'b0, 0);
    chk("t1 position after 10", int'(pos_o[0]), 501);
    chk("t1 damage_out", int'(dmg_o[0]), 0);

    // Attack cadence with ATK_PERIOD=2.
    do_reset();
    front[0] = 9'd511;
    spawn_unit(0, 3);
    att_cnt = 0;
    step(0, 1'b1, 1'b0, 0); seq[0] = int'(dmg_o[0]); att_cnt += int'(att_o[0]);
    step(0, 1'b0, 1'b0, 0);
    chk("t2 damage held", int'(dmg_o[0]), 128);
    chk("t2 attacking single cycle", int'(att_o[0]), 0);
    for (int i = 1; i < 4; i++) begin
      step(0, 1'b1, 1'b0, 0); seq[i] = int'(dmg_o[0]); att_cnt += int'(att_o[0]);
    end
    chk("t2 dmg seq0", seq[0], 128);
    chk("t2 dmg seq1", seq[1], 0);
    chk("t2 dmg seq2", seq[2], 128);
    chk("t2 dmg seq3", seq[3], 0);
    chk("t2 attack pulses", att_cnt, 2);

    // Damage to exactly zero health, then the death hold.
    do_reset();
    front[0] = 9'd0;
    spawn_unit(0, 2);
    step(0, 1'b1, 1'b0, 0);
    step(0, 1'b1, 1'b0, 0);
    chk("t3 moved", int'(pos_o[0]), 509);
    step(0, 1'b0, 1'b1, 100);
    chk("t3 survives 100", int'(type_o[0]), 2);
    step(0, 1'b0, 1'b1, 91);
    chk("t3 dying type", int'(type_o[0]), 0);
    chk("t3 dying dead", int'(dead_o[0]), 0);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 0);
    chk("t3 still holding", int'(dead_o[0]), 0);
    chk("t3 hold position", int'(pos_o[0]), 509);
    step(0, 1'b1, 1'b0, 0);
    chk("t3 slot free", int'(dead_o[0]), 1);
    chk("t3 back at spawn", int'(pos_o[0]), 511);

    // One short of lethal, then lethal hit together with an attack tick.
    do_reset();
    front[0] = 9'd511;
    spawn_unit(0, 1);
    step(0, 1'b0, 1'b1, 254);
    chk("t4 survives 254", int'(type_o[0]), 1);
    step(0, 1'b1, 1'b0, 0);
    chk("t4 attack", int'(dmg_o[0]), 32);
    step(0, 1'b1, 1'b1, 255);
    chk("t4 kill damage_out", int'(dmg_o[0]), 0);
    chk("t4 kill attacking", int'(att_o[0]), 0);
    chk("t4 kill type", int'(type_o[0]), 0);

    // DIR=1 runs up to the top end and stays there; spawn_req ignored while fighting.
    do_reset();
    front[1] = 9'd511;
    spawn_unit(1, 1);
    chk("t5 spawn position", int'(pos_o[1]), 0);
    tick[1] = 1'b1;
    repeat (300) @(negedge clk);
    spawn[1] = 1'b1; stype[1] = 2'd2;
    @(negedge clk);
    spawn[1] = 1'b0;
    repeat (250) @(negedge clk);
    tick[1] = 1'b0;
    @(negedge clk);
    chk("t5 position capped", int'(pos_o[1]), 511);
    chk("t5 at_base", int'(base_o[1]), 1);
    chk("t5 type unchanged", int'(type_o[1]), 1);

    // Asynchronous reset while an attack pulse is showing.
    do_reset();
    front[0] = 9'd511;
    spawn_unit(0, 3);
    step(0, 1'b1, 1'b0, 0);
    chk("t6 attacking before reset", int'(att_o[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6 position", int'(pos_o[0]), 511);
    chk("t6 damage_out", int'(dmg_o[0]), 0);
    chk("t6 unit_type", int'(type_o[0]), 0);
    chk("t6 dead", int'(dead_o[0]), 1);
    chk("t6 attacking", int'(att_o[0]), 0);
    @(negedge clk);
    #2 reset = 1'b0;

`ifdef UNIT_REGEN_EN
    do_reset();
    front[0] = 9'd0;
    spawn_unit(0, 1);
    step(0, 1'b0, 1'b1, 55);
    for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 0);
    step(0, 1'b0, 1'b1, 201);
    chk("regen survives 201", int'(type_o[0]), 1);
    step(0, 1'b0, 1'b1, 1);
    chk("regen dies at 202", int'(type_o[0]), 0);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
